ice_risc_rv_core: RTL and testbench

- Single-cycle RV32I integer core; executes one instruction per clock.
- Two combinational read ports: port 1 for instruction fetch, port 2 for load data.
- One byte-strobed write port for stores.
- Connects directly to the simulation memory model: reads are asynchronous, writes commit on the rising clock edge.

---
 rtl/ice_risc_rv_core.sv | 209 ++++++++++++++++++++
 tb/tb_ice_risc_rv_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ice_risc_rv_core.sv
// ice_risc_rv_core: single-cycle RV32I core; one instruction retires per rising iClk edge.
// Optional MUL/MULH/MULHSU/MULHU datapath enabled by defining ICE_RISC_RV_MUL_EN.
module ice_risc_rv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic [31:0] oRead1Addr,
  output logic [31:0] oRead2Addr,
  output logic [31:0] oWriteAddr,
  output logic [31:0] oWriteData,
  output logic [3:0]  oWstrb,
  input  logic [31:0] iRead1Data,
  input  logic [31:0] iRead2Data
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr  = iRead1Data;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] rs1_val, rs2_val, ea, pc_plus4;
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  // Address adder is shared by loads, stores and JALR target.
  assign ea       = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  assign oRead1Addr = pc_q;
  assign oRead2Addr = {ea[31:2], 2'b00};
  assign oWriteAddr = {ea[31:2], 2'b00};

  logic [31:0] op_b, alu_res;
  logic        alu_ok, alt;

  always_comb begin
    op_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
    alt     = (funct7 == 7'b0100000);
    alu_res = 32'd0;
    alu_ok  = 1'b0;
    if (opcode == OPC_OPIMM) begin
      alu_ok = (funct3 == 3'b001) ? (funct7 == 7'd0) :
               (funct3 == 3'b101) ? ((funct7 == 7'd0) || alt) : 1'b1;
    end else if (opcode == OPC_OP) begin
      alu_ok = (funct7 == 7'd0) || (alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end
    case (funct3)
      3'b000:  alu_res = (opcode == OPC_OP && alt) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu_res = rs1_val << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, rs1_val < op_b};
      3'b100:  alu_res = rs1_val ^ op_b;
      3'b101:  alu_res = alt ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110:  alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

`ifdef ICE_RISC_RV_MUL_EN
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_p;
  logic        [31:0] mul_res;

  // Operands widened to 33 bits so one signed multiplier covers all three signedness mixes.
  always_comb begin
    mul_a   = {(funct3 != 3'b011) & rs1_val[31], rs1_val};
    mul_b   = {(funct3[1] == 1'b0) & rs2_val[31], rs2_val};
    mul_p   = mul_a * mul_b;
    mul_res = (funct3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];
  end
`endif

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign ld_byte = iRead2Data[{ea[1:0], 3'b000} +: 8];
  assign ld_half = ea[1] ? iRead2Data[31:16] : iRead2Data[15:0];

  logic        rd_we;
  logic [31:0] rd_val;
  logic [3:0]  store_strb;
  logic [31:0] store_data;

  always_comb begin
    pc_d       = pc_plus4;
    rd_we      = 1'b0;
    rd_val     = 32'd0;
    store_strb = 4'b0000;
    store_data = rs2_val;
    case (opcode)
      OPC_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we  = 1'b1;
        rd_val = pc_plus4;
        pc_d   = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we  = 1'b1;
          rd_val = pc_plus4;
          pc_d   = {ea[31:1], 1'b0};
        end
      end
      OPC_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OPC_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_val = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rd_val = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_val = iRead2Data;
          3'b100:  rd_val = {24'd0, ld_byte};
          3'b101:  rd_val = {16'd0, ld_half};
          default: rd_we  = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: begin
            store_data = {4{rs2_val[7:0]}};
            store_strb = 4'b0001 << ea[1:0];
          end
          3'b001: begin
            store_data = {2{rs2_val[15:0]}};
            store_strb = ea[1] ? 4'b1100 : 4'b0011;
          end
          3'b010:  store_strb = 4'b1111;
          default: store_strb = 4'b0000;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        if (alu_ok) begin
          rd_we  = 1'b1;
          rd_val = alu_res;
        end
`ifdef ICE_RISC_RV_MUL_EN
        if (opcode == OPC_OP && funct7 == 7'b0000001 && !funct3[2]) begin
          rd_we  = 1'b1;
          rd_val = mul_res;
        end
`endif
      end
      default: ;
    endcase
  end

  assign oWriteData = store_data;
  // Reset must not let the instruction sitting at the fetch port corrupt memory.
  assign oWstrb     = iRst ? 4'b0000 : store_strb;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_ice_risc_rv_core.sv
// Directed-program bench: expected fetch addresses and store transactions are queued up front,
// a negedge monitor pops and compares them as the core presents them.
module tb_ice_risc_rv_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1_addr, rd2_addr, wr_addr, wr_data, rd1_data, rd2_data;
  logic [3:0]  wstrb;

  ice_risc_rv_core #(.RESET_PC(32'h0)) dut (
    .iClk(clk), .iRst(rst),
    .oRead1Addr(rd1_addr), .oRead2Addr(rd2_addr),
    .oWriteAddr(wr_addr), .oWriteData(wr_data), .oWstrb(wstrb),
    .iRead1Data(rd1_data), .iRead2Data(rd2_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  logic [31:0] wr_word;
  assign rd1_data = mem[rd1_addr[8:2]];
  assign rd2_data = mem[rd2_addr[8:2]];

  always @(posedge clk) begin
    wr_word = mem[wr_addr[8:2]];
    for (int n = 0; n < 4; n++)
      if (wstrb[n]) wr_word[8*n +: 8] = wr_data[8*n +: 8];
    if (wstrb != 4'b0) mem[wr_addr[8:2]] <= wr_word;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  st_t         exp_st[$];
  logic [31:0] exp_pc[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  // Instruction encoders (assembler helpers only).
  function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rdd, logic [6:0] op);
    logic [31:0] v; v = imm;
    return {v[11:0], 5'(r1), 3'(f3), 5'(rdd), op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, int r2, int r1, int f3, int rdd);
    return {f7, 5'(r2), 5'(r1), 3'(f3), 5'(rdd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
    logic [31:0] v; v = imm;
    return {v[11:5], 5'(r2), 5'(r1), 3'(f3), v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int r2, int r1, int f3);
    logic [31:0] v; v = imm;
    return {v[12], v[10:5], 5'(r2), 5'(r1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, int rdd, logic [6:0] op);
    return {imm, 5'(rdd), op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rdd);
    logic [31:0] v; v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rdd), 7'b1101111};
  endfunction

  localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011, JALR = 7'b1100111;

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[8:2]] = w;
  endtask
  task automatic exp_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_st.push_back('{addr: a, data: d, strb: s});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] p;
      st_t         e;
      vectors++;
      if (exp_pc.size() == 0) begin
        miscompares++;
        $display("FAIL pc_extra: fetch 0x%08h with no expected fetch left", rd1_addr);
      end else begin
        p = exp_pc.pop_front();
        if (rd1_addr !== p) begin
          miscompares++;
          $display("FAIL pc: fetch 0x%08h, expected 0x%08h", rd1_addr, p);
        end
      end
      if (rst) begin
        vectors++;
        if (wstrb !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_wstrb: wstrb %b, expected 0000", wstrb);
        end
      end else if (wstrb !== 4'b0000) begin
        vectors++;
        if (exp_st.size() == 0) begin
          miscompares++;
          $display("FAIL store_extra: addr 0x%08h data 0x%08h strb %b, none expected", wr_addr, wr_data, wstrb);
        end else begin
          e = exp_st.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data || wstrb !== e.strb) begin
            miscompares++;
            $display("FAIL store: got addr 0x%08h data 0x%08h strb %b, expected addr 0x%08h data 0x%08h strb %b",
                     wr_addr, wr_data, wstrb, e.addr, e.data, e.strb);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] pcs[$];
    bit          done;
    rst = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;

    put(32'h00, enc_s(32'h108, 0, 0, 2));        // SW x0,0x108(x0)
    put(32'h04, enc_i(5, 0, 0, 1, OPIMM));        // ADDI x1,x0,5
    put(32'h08, enc_i(-7, 1, 0, 2, OPIMM));       // ADDI x2,x1,-7
    put(32'h0C, enc_s(32'h100, 2, 0, 2));         // SW x2,0x100(x0)
    put(32'h10, enc_i(9, 0, 0, 0, OPIMM));        // ADDI x0,x0,9
    put(32'h14, enc_j(32'hC, 0));                 // JAL x0,+0xC
    put(32'h18, enc_s(32'h104, 0, 0, 2));         // SW x0,0x104(x0)
    put(32'h1C, enc_j(8, 0));                     // JAL x0,+8
    put(32'h20, enc_b(-8, 0, 0, 0));              // BEQ x0,x0,-8
    put(32'h24, enc_u(20'h12345, 3, 7'b0110111)); // LUI x3
    put(32'h28, enc_i(32'h678, 3, 0, 3, OPIMM));  // ADDI x3,x3,0x678
    put(32'h2C, enc_s(32'h103, 3, 0, 0));         // SB x3,0x103(x0)
    put(32'h30, enc_u(20'h80000, 4, 7'b0110111)); // LUI x4,0x80000
    put(32'h34, enc_s(32'h100, 4, 0, 2));         // SW x4,0x100(x0)
    put(32'h38, enc_i(32'h103, 0, 0, 5, LOAD));   // LB x5,0x103(x0)
    put(32'h3C, enc_s(32'h110, 5, 0, 2));
    put(32'h40, enc_j(32'h10, 1));                // JAL x1,+0x10
    put(32'h44, enc_i(32'h103, 0, 4, 8, LOAD));   // LBU x8,0x103(x0)
    put(32'h48, enc_i(32'h102, 0, 5, 7, LOAD));   // LHU x7,0x102(x0)
    put(32'h4C, enc_j(32'h14, 0));
    put(32'h50, enc_s(32'h114, 1, 0, 2));
    put(32'h54, enc_i(32'h45, 0, 0, 5, OPIMM));
    put(32'h58, enc_i(0, 5, 0, 0, JALR));         // JALR x0,0(x5)
    put(32'h60, enc_u(20'h00001, 6, 7'b0010111)); // AUIPC x6,1
    put(32'h64, enc_s(32'h118, 8, 0, 2));
    put(32'h68, enc_s(32'h11C, 7, 0, 2));
    put(32'h6C, enc_s(32'h120, 6, 0, 2));
    put(32'h70, enc_u(20'h12345, 5, 7'b0110111));
    put(32'h74, enc_s(32'h124, 5, 0, 2));
    put(32'h78, enc_i(-1, 0, 0, 9, OPIMM));
    put(32'h7C, enc_i(1, 0, 0, 10, OPIMM));
    put(32'h80, enc_b(8, 10, 9, 4));              // BLT x9,x10,+8
    put(32'h84, enc_s(32'h128, 9, 0, 2));
    put(32'h88, enc_b(8, 10, 9, 6));              // BLTU x9,x10,+8
    put(32'h8C, enc_s(32'h12C, 10, 0, 2));
    put(32'h90, 32'h0000_0000);
    put(32'h94, enc_r(7'b0100000, 9, 10, 0, 11)); // SUB x11,x10,x9
    put(32'h98, enc_r(7'b0000000, 10, 9, 2, 12)); // SLT
    put(32'h9C, enc_r(7'b0000000, 10, 9, 3, 13)); // SLTU
    put(32'hA0, enc_i(32'h404, 4, 5, 14, OPIMM)); // SRAI x14,x4,4
    put(32'hA4, enc_i(4, 4, 5, 15, OPIMM));       // SRLI x15,x4,4
    put(32'hA8, enc_r(7'b0000000, 9, 3, 4, 16));  // XOR x16,x3,x9
    for (int i = 0; i < 6; i++) put(32'hAC + 4*i, enc_s(32'h130 + 4*i, 11 + i, 0, 2));
    put(32'hC4, enc_s(32'h102, 3, 0, 1));         // SH x3,0x102(x0)
    put(32'hC8, enc_i(32'h102, 0, 1, 17, LOAD));  // LH x17,0x102(x0)
    put(32'hCC, enc_s(32'h148, 17, 0, 2));
    put(32'hD0, enc_j(0, 0));                     // JAL x0,0

    pcs = '{32'h00, 32'h00, 32'h00,
            32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h18, 32'h1C, 32'h24,
            32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h50, 32'h54, 32'h58,
            32'h44, 32'h48, 32'h4C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78,
            32'h7C, 32'h80, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h98, 32'h9C, 32'hA0, 32'hA4,
            32'hA8, 32'hAC, 32'hB0, 32'hB4, 32'hB8, 32'hBC, 32'hC0, 32'hC4, 32'hC8, 32'hCC,
            32'hD0, 32'hD0, 32'hD0};
    foreach (pcs[i]) exp_pc.push_back(pcs[i]);

    exp_store(32'h108, 32'h0000_0000, 4'b1111);
    exp_store(32'h100, 32'hFFFF_FFFE, 4'b1111);
    exp_store(32'h104, 32'h0000_0000, 4'b1111);
    exp_store(32'h100, 32'h7878_7878, 4'b1000);
    exp_store(32'h100, 32'h8000_0000, 4'b1111);
    exp_store(32'h110, 32'hFFFF_FF80, 4'b1111);
    exp_store(32'h114, 32'h0000_0044, 4'b1111);
    exp_store(32'h118, 32'h0000_0080, 4'b1111);
    exp_store(32'h11C, 32'h0000_8000, 4'b1111);
    exp_store(32'h120, 32'h0000_1060, 4'b1111);
    exp_store(32'h124, 32'h1234_5000, 4'b1111);
    exp_store(32'h12C, 32'h0000_0001, 4'b1111);
    exp_store(32'h130, 32'h0000_0002, 4'b1111);
    exp_store(32'h134, 32'h0000_0001, 4'b1111);
    exp_store(32'h138, 32'h0000_0000, 4'b1111);
    exp_store(32'h13C, 32'hF800_0000, 4'b1111);
    exp_store(32'h140, 32'h0800_0000, 4'b1111);
    exp_store(32'h144, 32'hEDCB_A987, 4'b1111);
    exp_store(32'h100, 32'h5678_5678, 4'b1100);
    exp_store(32'h148, 32'h0000_5678, 4'b1111);

    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_pc.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    mon_en = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d fetches still expected after cycle budget", exp_pc.size());
    end
    vectors++;
    if (exp_st.size() != 0) begin
      miscompares++;
      $display("FAIL missing_store: %0d stores not seen, expected 0", exp_st.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
